// File: rtl/anfsqrt_pkg.sv
// Shared widths and FSM encoding for the anfsqrt arbiter family.
package anfsqrt_pkg;

  localparam int QUERY_W  = 32;
  localparam int RESULT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_t;

endpackage

// File: rtl/anfsqrt_rr_pick.sv
// Combinational round-robin picker: first requester above i_rr_ptr wins, wrapping modulo NUM_REQ.
module anfsqrt_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_rr_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_grant_id,
  output logic               o_any
);

  always_comb begin
    logic [ID_W-1:0] w_idx;
    o_grant    = '0;
    o_grant_id = '0;
    o_any      = 1'b0;
    w_idx      = '0;
    // k=NUM_REQ revisits i_rr_ptr itself, so the last owner is served only when alone.
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = ID_W'((int'(i_rr_ptr) + k) % NUM_REQ);
      if (!o_any && i_req[w_idx]) begin
        o_any          = 1'b1;
        o_grant_id     = w_idx;
        o_grant[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/anfsqrt_arbiter.sv
// Round-robin arbiter sharing one sqrt unit among NUM_REQ requesters, one query in flight.
// Optional macro ANFSQRT_ARB_ZERO_BYPASS_EN: zero radicands skip the sqrt unit and answer 0 directly.
module anfsqrt_arbiter
  import anfsqrt_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [QUERY_W*NUM_REQ-1:0]  req_query,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          resp_valid,
  input  logic [NUM_REQ-1:0]          resp_ready,
  output logic [RESULT_W-1:0]         resp_result,
  output logic [ID_W-1:0]             resp_id,
  output logic [QUERY_W-1:0]          sq_query,
  output logic                        sq_query_valid,
  input  logic                        sq_query_ready,
  input  logic [RESULT_W-1:0]         sq_result,
  input  logic                        sq_result_valid
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [QUERY_W-1:0]    r_query;
  logic [ID_W-1:0]       r_owner;
  logic [ID_W-1:0]       r_rr_ptr;
  logic [RESULT_W-1:0]   r_resp_result;
  logic [ID_W-1:0]       r_resp_id;

  logic [NUM_REQ-1:0]    w_grant;
  logic [ID_W-1:0]       w_grant_id;
  logic                  w_any;
  logic [QUERY_W-1:0]    w_win_query;
  logic                  w_accept;
  logic                  w_zero;
  logic                  w_resp_hs;

  anfsqrt_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .i_req      (req_valid),
    .i_rr_ptr   (r_rr_ptr),
    .o_grant    (w_grant),
    .o_grant_id (w_grant_id),
    .o_any      (w_any)
  );

  always_comb begin
    w_win_query = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_grant[k]) w_win_query = req_query[k*QUERY_W +: QUERY_W];
    end
  end

`ifdef ANFSQRT_ARB_ZERO_BYPASS_EN
  assign w_zero = (w_win_query == '0);
`else
  assign w_zero = 1'b0;
`endif

  assign w_accept  = (r_state == IDLE) && w_any;
  assign w_resp_hs = (r_state == RESP) && resp_ready[r_owner];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    req_ready      = '0;
    resp_valid     = '0;
    sq_query_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        req_ready = w_grant;
        if (w_any) w_state_nxt = w_zero ? RESP : ISSUE;
      end
      ISSUE: begin
        // The unit offers no separate ack: valid only ever rises together with ready.
        sq_query_valid = sq_query_ready;
        if (sq_query_ready) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (sq_result_valid) w_state_nxt = RESP;
      end
      RESP: begin
        resp_valid[r_owner] = 1'b1;
        if (resp_ready[r_owner]) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_query       <= '0;
      r_owner       <= '0;
      r_rr_ptr      <= ID_W'(NUM_REQ - 1);
      r_resp_result <= '0;
      r_resp_id     <= '0;
    end else begin
      if (w_accept) begin
        r_query <= w_win_query;
        r_owner <= w_grant_id;
        if (w_zero) begin
          r_resp_result <= '0;
          r_resp_id     <= w_grant_id;
        end
      end
      // The unit's result is a bare pulse; only the one awaited in WAIT is captured.
      if (r_state == WAIT && sq_result_valid) begin
        r_resp_result <= sq_result;
        r_resp_id     <= r_owner;
      end
      if (w_resp_hs) r_rr_ptr <= r_owner;
    end
  end

  assign sq_query    = r_query;
  assign resp_result = r_resp_result;
  assign resp_id     = r_resp_id;

endmodule

// File: tb/tb_anfsqrt_arbiter.sv
// Self-checking bench for anfsqrt_arbiter with a behavioural sqrt-unit model and round-robin reference.
module tb_anfsqrt_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [NREQ-1:0]      req_valid;
  logic [32*NREQ-1:0]   req_query;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      resp_valid;
  logic [NREQ-1:0]      resp_ready;
  logic [15:0]          resp_result;
  logic [IDW-1:0]       resp_id;
  logic [31:0]          sq_query;
  logic                 sq_query_valid;
  logic                 sq_query_ready;
  logic [15:0]          sq_result = '0;
  logic                 sq_result_valid = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  anfsqrt_arbiter #(.NUM_REQ(NREQ), .ID_W(IDW)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_valid       (req_valid),
    .req_query       (req_query),
    .req_ready       (req_ready),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_result     (resp_result),
    .resp_id         (resp_id),
    .sq_query        (sq_query),
    .sq_query_valid  (sq_query_valid),
    .sq_query_ready  (sq_query_ready),
    .sq_result       (sq_result),
    .sq_result_valid (sq_result_valid)
  );

  function automatic logic [15:0] isqrt(input logic [31:0] x);
    logic [15:0] r;
    longint unsigned t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = 64'(r) | (64'd1 << b);
      if (t * t <= 64'(x)) r = 16'(t);
    end
    return r;
  endfunction

  // Behavioural sqrt unit: idle/ready, fixed or random 1..16 cycle latency, one-cycle result pulse.
  logic        m_busy = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_q = '0;
  bit          m_gate = 1'b1;
  int          fixed_lat = 0;
  bit          spur_en = 1'b0;
  int          sq_hs_cnt = 0;
  logic [31:0] sq_log[$];

  assign sq_query_ready = !m_busy && m_gate;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy          <= 1'b0;
      m_cnt           <= 0;
      sq_result_valid <= 1'b0;
    end else begin
      sq_result_valid <= 1'b0;
      if (m_busy) begin
        if (m_cnt <= 1) begin
          sq_result_valid <= 1'b1;
          sq_result       <= isqrt(m_q);
          m_busy          <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 1;
        end
      end else if (sq_query_valid && sq_query_ready) begin
        m_busy    <= 1'b1;
        m_q       <= sq_query;
        m_cnt     <= (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 16));
        sq_hs_cnt <= sq_hs_cnt + 1;
        sq_log.push_back(sq_query);
      end else if (spur_en && $urandom_range(0, 3) == 0) begin
        sq_result_valid <= 1'b1;
        sq_result       <= 16'($urandom);
      end
    end
  end

  logic [31:0] jobs[NREQ][$];
  int          exp_ptr = NREQ - 1;
  int          exp_id[$];
  logic [15:0] exp_res[$];
  logic [31:0] exp_sq[$];
  int          got_id[$];
  logic [15:0] got_res[$];
  int          proto_err;

  // Reference: each arbitration serves the first requester with work after the last served one.
  task automatic model_order();
    logic [31:0] cp[NREQ][$];
    logic [31:0] q;
    int          pick;
    bit          done;
    exp_id.delete(); exp_res.delete(); exp_sq.delete();
    for (int i = 0; i < NREQ; i++) cp[i] = jobs[i];
    done = 1'b0;
    while (!done) begin
      pick = -1;
      for (int k = 1; k <= NREQ; k++) begin
        if (pick < 0 && cp[(exp_ptr + k) % NREQ].size() > 0) pick = (exp_ptr + k) % NREQ;
      end
      if (pick < 0) begin
        done = 1'b1;
      end else begin
        q = cp[pick].pop_front();
        exp_id.push_back(pick);
        exp_res.push_back(isqrt(q));
`ifdef ANFSQRT_ARB_ZERO_BYPASS_EN
        if (q != 0) exp_sq.push_back(q);
`else
        exp_sq.push_back(q);
`endif
        exp_ptr = pick;
      end
    end
  endtask

  task automatic test_reset();
    int hs0;
    reset_n = 1'b0; req_valid = '0; req_query = '0; resp_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if ({req_ready, resp_valid, sq_query_valid} !== '0)
      $display("FAIL reset_ctrl: req_ready=%b resp_valid=%b sq_query_valid=%b, want all 0", req_ready, resp_valid, sq_query_valid);
    total++; if (sq_query !== 32'd0) begin bad++; $display("FAIL reset_sq_query: got %h want 0", sq_query); end
    total++; if (resp_result !== 16'd0 || resp_id !== '0)
      begin bad++; $display("FAIL reset_resp: result=%h id=%0d want 0/0", resp_result, resp_id); end
    if ({req_ready, resp_valid, sq_query_valid} !== '0) bad++;
    reset_n = 1'b1;
    exp_ptr = NREQ - 1;
    @(negedge clk);
    total++; if (req_ready !== '0) begin bad++; $display("FAIL reset_idle_ready: got %b want 0", req_ready); end
    hs0 = sq_hs_cnt;
    req_valid = '1;
    #1;
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL reset_first_winner: got %b want 0001", req_ready); end
    req_valid = '0;
    repeat (4) begin @(posedge clk); #1; end
    total++; if (sq_hs_cnt != hs0 || resp_valid !== '0)
      begin bad++; $display("FAIL dropped_req: sq handoffs=%0d resp_valid=%b, want 0 and 0", sq_hs_cnt - hs0, resp_valid); end
  endtask

  task automatic test_stream(input string nm, input bit rand_rdy, input int max_cyc);
    int              remaining;
    int              cyc;
    int              k;
    logic [NREQ-1:0] prev_rv;
    logic [15:0]     prev_res;
    model_order();
    sq_log.delete(); got_id.delete(); got_res.delete();
    proto_err = 0; remaining = 0; cyc = 0; prev_rv = '0; prev_res = '0;
    for (int i = 0; i < NREQ; i++) remaining += jobs[i].size();
    while (remaining > 0 && cyc < max_cyc) begin
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i] = (jobs[i].size() > 0);
        req_query[32*i +: 32] = (jobs[i].size() > 0) ? jobs[i][0] : $urandom;
      end
      resp_ready = rand_rdy ? NREQ'($urandom) : '1;
      m_gate = rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      if (!$onehot0(req_ready) || (req_ready & ~req_valid) != '0) proto_err++;
      if (sq_query_valid && !sq_query_ready) proto_err++;
      if ((req_valid & req_ready) != '0) begin
        k = 0;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) k = i;
        void'(jobs[k].pop_front());
      end
      if (resp_valid != '0) begin
        if (!$onehot(resp_valid) || resp_valid !== (4'b1 << resp_id) || req_ready != '0) proto_err++;
        if (prev_rv == resp_valid && prev_res !== resp_result) proto_err++;
        if ((resp_valid & resp_ready) != '0) begin
          got_id.push_back(int'(resp_id));
          got_res.push_back(resp_result);
          remaining--;
          prev_rv = '0;
        end else begin
          prev_rv = resp_valid;
        end
      end else begin
        prev_rv = '0;
      end
      prev_res = resp_result;
      @(posedge clk); #1;
      cyc++;
    end
    req_valid = '0; resp_ready = '0; m_gate = 1'b1;
    for (int i = 0; i < NREQ; i++) jobs[i].delete();
    total++; if (remaining != 0) begin bad++; $display("FAIL %s timeout: %0d responses outstanding, want 0", nm, remaining); end
    total++; if (got_id.size() != exp_id.size())
      begin bad++; $display("FAIL %s resp_count: got %0d want %0d", nm, got_id.size(), exp_id.size()); end
    for (int n = 0; n < got_id.size() && n < exp_id.size(); n++) begin
      total++; if (got_id[n] != exp_id[n] || got_res[n] !== exp_res[n])
        begin bad++; $display("FAIL %s resp[%0d]: got id=%0d res=%0d want id=%0d res=%0d", nm, n, got_id[n], got_res[n], exp_id[n], exp_res[n]); end
    end
    total++; if (sq_log.size() != exp_sq.size())
      begin bad++; $display("FAIL %s sq_handoffs: got %0d want %0d", nm, sq_log.size(), exp_sq.size()); end
    for (int n = 0; n < sq_log.size() && n < exp_sq.size(); n++) begin
      total++; if (sq_log[n] !== exp_sq[n])
        begin bad++; $display("FAIL %s sq_query[%0d]: got %h want %h", nm, n, sq_log[n], exp_sq[n]); end
    end
    total++; if (proto_err != 0) begin bad++; $display("FAIL %s protocol: %0d violations, want 0", nm, proto_err); end
  endtask

  task automatic test_backpressure();
    bit ok;
    bit stable;
    req_query[63:32] = 32'd100; req_valid = 4'b0010; resp_ready = '0;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk); if (req_ready == 4'b0010) ok = 1'b1;
      @(posedge clk); #1;
    end
    total++; if (!ok) begin bad++; $display("FAIL bp_grant: req_ready never 0010"); end
    req_valid = 4'b1000; req_query[127:96] = 32'd9; resp_ready = 4'b1101;
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (resp_valid != '0) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    total++; if (!ok || resp_valid !== 4'b0010) begin bad++; $display("FAIL bp_resp: resp_valid=%b want 0010", resp_valid); end
    stable = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (resp_valid !== 4'b0010 || resp_result !== 16'd10 || resp_id !== 2'd1 || req_ready !== '0) stable = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
    end
    total++; if (!stable)
      begin bad++; $display("FAIL bp_hold: rv=%b res=%0d id=%0d rr=%b want 0010/10/1/0000", resp_valid, resp_result, resp_id, req_ready); end
    resp_ready = 4'b0010;
    #1;
    total++; if (req_ready !== '0) begin bad++; $display("FAIL bp_same_cycle_grant: req_ready=%b want 0000", req_ready); end
    @(posedge clk); #1;
    resp_ready = '0;
    @(negedge clk);
    total++; if (resp_valid !== '0 || req_ready !== 4'b1000)
      begin bad++; $display("FAIL bp_next_grant: rv=%b rr=%b want 0000/1000", resp_valid, req_ready); end
    @(posedge clk); #1;
    req_valid = '0; resp_ready = 4'b1000;
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (resp_valid != '0) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    total++; if (!ok || resp_valid !== 4'b1000 || resp_result !== 16'd3 || resp_id !== 2'd3)
      begin bad++; $display("FAIL bp_second: rv=%b res=%0d id=%0d want 1000/3/3", resp_valid, resp_result, resp_id); end
    @(posedge clk); #1;
    resp_ready = '0;
    exp_ptr = 3;
  endtask

  task automatic test_zero();
    bit ok;
    int hs0;
    hs0 = sq_hs_cnt;
    req_query[63:32] = 32'd0; req_valid = 4'b0010; resp_ready = '0;
    ok = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin
      @(negedge clk); if (req_ready == 4'b0010) ok = 1'b1;
      @(posedge clk); #1;
    end
    req_valid = '0;
    total++; if (!ok) begin bad++; $display("FAIL zero_grant: req_ready never 0010"); end
`ifdef ANFSQRT_ARB_ZERO_BYPASS_EN
    @(negedge clk);
`else
    ok = 1'b0;
    for (int c = 0; c < 40 && !ok; c++) begin
      @(negedge clk);
      if (resp_valid != '0) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
`endif
    total++; if (resp_valid !== 4'b0010 || resp_result !== 16'd0 || resp_id !== 2'd1)
      begin bad++; $display("FAIL zero_resp: rv=%b res=%0d id=%0d want 0010/0/1", resp_valid, resp_result, resp_id); end
    resp_ready = 4'b0010;
    @(posedge clk); #1;
    resp_ready = '0;
`ifdef ANFSQRT_ARB_ZERO_BYPASS_EN
    total++; if (sq_hs_cnt != hs0) begin bad++; $display("FAIL zero_sq_strobe: got %0d handoffs want 0", sq_hs_cnt - hs0); end
`else
    total++; if (sq_hs_cnt != hs0 + 1) begin bad++; $display("FAIL zero_sq_strobe: got %0d handoffs want 1", sq_hs_cnt - hs0); end
`endif
    exp_ptr = 1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    int hs0;
    fixed_lat = 16;
    hs0 = sq_hs_cnt;
    req_query[95:64] = 32'h1234_5678; req_valid = 4'b0100; resp_ready = '0;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      @(negedge clk); if (req_ready[2]) ok = 1'b1;
      @(posedge clk); #1;
    end
    req_valid = '0;
    ok = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin
      if (sq_hs_cnt != hs0) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    total++; if (!ok) begin bad++; $display("FAIL rstmid_issue: no sq handoff seen"); end
    repeat (3) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    #1;
    total++; if ({req_ready, resp_valid, sq_query_valid} !== '0)
      begin bad++; $display("FAIL rstmid_ctrl: rr=%b rv=%b sqv=%b want 0", req_ready, resp_valid, sq_query_valid); end
    total++; if (sq_query !== 32'd0 || resp_result !== 16'd0 || resp_id !== '0)
      begin bad++; $display("FAIL rstmid_data: sq=%h res=%h id=%0d want 0", sq_query, resp_result, resp_id); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    fixed_lat = 0;
    exp_ptr = NREQ - 1;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk); if (resp_valid != '0 || sq_query_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    total++; if (seen) begin bad++; $display("FAIL rstmid_ghost: activity after reset, want none"); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q;
    int          sel;
    test_reset();

    jobs[0].push_back(32'd16); jobs[1].push_back(32'd25);
    jobs[2].push_back(32'd36); jobs[3].push_back(32'd49);
    test_stream("simultaneous", 1'b0, 400);

    jobs[1].push_back(32'd64); jobs[3].push_back(32'd121);
    test_stream("rerequest", 1'b0, 200);

    jobs[0].push_back(32'd144);
    test_stream("single", 1'b0, 100);

    jobs[2].push_back(32'hFFFF_FFFF); jobs[2].push_back(32'd1);
    test_stream("fullscale", 1'b1, 300);

    test_backpressure();
    test_zero();
    test_reset_mid();

    jobs[0].push_back(32'd81);
    test_stream("after_reset", 1'b0, 100);

    spur_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 4));
      case (sel)
        0:       q = 32'd0;
        1:       q = 32'hFFFF_FFFF;
        2:       q = 32'($urandom_range(0, 300));
        3:       begin q = 32'($urandom_range(0, 65535)); q = q * q; end
        default: q = $urandom;
      endcase
      jobs[$urandom_range(0, NREQ - 1)].push_back(q);
    end
    test_stream("random", 1'b1, 5000);
    spur_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/anfsqrt_arbiter.md
Name: anfsqrt_arbiter

Overview:
- Round-robin arbiter sharing one anfsqrt_sqrt unit (32-bit radicand, 16-bit floor root, query/result handshake) among NUM_REQ requesters.
- Sits between the requester clients and the sqrt unit's query/result ports. Owns issue sequencing and response buffering.
- One query outstanding at a time. The result is held until the owning requester accepts it, because the sqrt unit's result_valid is a one-cycle pulse with no backpressure.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, $clog2(NUM_REQ), width of the grant index.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester query valid.
- req_query  in  32*NUM_REQ  per-requester radicand; requester i occupies bits [32*i+31:32*i].
- req_ready  out  NUM_REQ  per-requester accept strobe; at most one bit high.
- resp_valid  out  NUM_REQ  per-requester result valid; at most one bit high.
- resp_ready  in  NUM_REQ  per-requester result accept.
- resp_result  out  16  shared result bus, meaningful only while a resp_valid bit is high.
- resp_id  out  ID_W  index of the requester currently owning resp_result.
- sq_query  out  32  radicand to the sqrt unit.
- sq_query_valid  out  1  query strobe to the sqrt unit.
- sq_query_ready  in  1  sqrt unit idle/ready.
- sq_result  in  16  sqrt unit result.
- sq_result_valid  in  1  sqrt unit one-cycle result pulse.

Behaviour:
- Reset values (asynchronous on reset_n low): state=IDLE, req_ready=0, resp_valid=0, sq_query_valid=0, sq_query=0, resp_result=0, resp_id=0, owner=0, rr_ptr=NUM_REQ-1 (so requester 0 wins first).
- The sqrt unit's own synchronous active-high reset must be driven from the same system reset. Reset mid-operation discards any in-flight query and any held result; no response is produced for it.

FSM:
- IDLE
  - Winner = first i with req_valid[i] set, searching from rr_ptr+1 upward, modulo NUM_REQ.
  - req_ready[winner]=1 combinationally in the same cycle.
  - On accept: latch query and owner=winner, go ISSUE.
  - No request pending: stay in IDLE.
- ISSUE
  - sq_query_valid=1 while sq_query_ready=1. The cycle where both are high is the handoff.
  - After the handoff: sq_query_valid=0, go WAIT.
  - sq_query_ready low: hold sq_query_valid low and wait.
- WAIT
  - On sq_result_valid: latch sq_result into resp_result, set resp_id=owner, go RESP.
  - A sq_result_valid pulse in any state other than WAIT is ignored.
- RESP
  - resp_valid[owner]=1, held with resp_result stable until resp_ready[owner]=1.
  - On that handshake: resp_valid=0, rr_ptr=owner, go IDLE.

Timing and ordering:
- Latency: 1 cycle accept + ISSUE wait + sqrt unit iterations (≤16) + 2 cycles + response wait.
- A new grant is possible in the cycle after the RESP handshake. No same-cycle RESP→grant.
- resp_ready on non-owner bits is ignored.
- req_valid dropping before acceptance is permitted; no grant is issued for a dropped request.
- Simultaneous requests are serialised by round-robin order.

Optional Feature:
- Macro ANFSQRT_ARB_ZERO_BYPASS_EN.
- When defined: in IDLE, an accepted query equal to 0 goes directly to RESP with resp_result=0. The sqrt unit is never strobed, so the result arrives 1 cycle after accept.
- When undefined: zero queries take the normal ISSUE/WAIT path. The unit returns 0 after its early-exit path.

Decomposition:
- Package anfsqrt_pkg holds:
  - QUERY_W=32 and RESULT_W=16.
  - The FSM state encoding: IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, RESP=2'b11.
- Sub-module anfsqrt_rr_pick: combinational round-robin picker.
  - Inputs: req vector and rr_ptr.
  - Outputs: one-hot grant, grant index, any-valid.
  - Reusable by other shared-datapath arbiters.

Test Plan:
- Single request: req 0 with query=144 → one sq_query_valid handoff with sq_query=144, then resp_valid[0] with resp_result=12 and resp_id=0.
- Full-scale query: query=0xFFFFFFFF from requester 2 → resp_result=0xFFFF; query=1 → resp_result=1.
- Simultaneous requests: all four valid in the same cycle with queries 16/25/36/49 → grant order 0,1,2,3; results 4,5,6,7. Then re-request 1 and 3 together with rr_ptr=3 → requester 1 is served before 3.
- Backpressure: hold resp_ready[owner] low for 10 cycles after the result → resp_valid and resp_result stay stable; resp_ready on other bits is ignored; no new req_ready until the handshake.
- Reset: assert reset_n low in WAIT, during the sqrt unit's iterations → all outputs return to reset values immediately; no resp_valid afterwards; the next request (query=81) returns 9.
- Zero query: query=0 with ANFSQRT_ARB_ZERO_BYPASS_EN defined → resp_valid 1 cycle after accept, resp_result=0, sq_query_valid never asserted. Without the macro → normal path, result 0.
